spi_slave_link: RTL and testbench

FPGA-side SPI slave terminating the host (Jetson) link. Each frame is 32 bits, MSB first: bits 31:28 hold the channel index and bits 27:0 hold the payload. The block deserializes host frames into an index/payload strobe for downstream channel logic. On the same frame it serializes one response word: a queued channel word if one is offered, otherwise the index-0 status word. It sits between the SPI pins and the per-channel command and response logic.

---
 rtl/spi_slave_link.sv | 157 +++++++++++++++
 tb/tb_spi_slave_link.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_link.sv
// SPI mode-0 slave for the host link: 32-bit frames {index[3:0], payload[27:0]}, MSB first.
// Optional saturating frame-error counter enabled by defining SPI_SLAVE_ERRCNT_EN.
module spi_slave_link #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_cs,
  output logic        rx_valid,
  output logic [3:0]  rx_index,
  output logic [27:0] rx_data,
  input  logic        tx_valid,
  input  logic [3:0]  tx_index,
  input  logic [27:0] tx_data,
  output logic        tx_ready,
  input  logic [27:0] status,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_s, mosi_s, cs_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [31:0] tx_sr_q, tx_sr_d;
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [3:0]  rx_index_q, rx_index_d;
  logic [27:0] rx_data_q, rx_data_d;
  logic        tx_ready_d;

  // Synchronizers are not reset so that CS seen during reset is already valid on release;
  // a CS still low after reset then keeps the block in WAIT_IDLE instead of faking a cs_fall.
  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sck_prev_q  <= sck_s;
    cs_prev_q   <= cs_s;
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign cs_rise  =  cs_s  & ~cs_prev_q;
  assign cs_fall  = ~cs_s  &  cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (cs_s)    state_d = IDLE;
      IDLE:      if (cs_fall) state_d = SHIFT;
      SHIFT:     if (cs_rise) state_d = IDLE;
      default:                state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    rx_index_d  = rx_index_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = 6'd0;
          if (tx_valid) begin
            tx_sr_d    = {tx_index, tx_data};
            tx_ready_d = ~rst;
          end else begin
            tx_sr_d = {4'h0, status};
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt_q == 6'd32) begin
            rx_valid_d = 1'b1;
            rx_index_d = rx_sr_q[31:28];
            rx_data_d  = rx_sr_q[27:0];
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            rx_sr_d = {rx_sr_q[30:0], mosi_s};
            if (bit_cnt_q < 6'd33) bit_cnt_d = bit_cnt_q + 6'd1;
          end
          if (sck_fall) tx_sr_d = {tx_sr_q[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rx_index_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_index_q  <= rx_index_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso  = tx_sr_q[31];
  assign rx_valid  = rx_valid_q;
  assign rx_index  = rx_index_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign tx_ready  = tx_ready_d;

`ifdef SPI_SLAVE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                    err_cnt_q <= '0;
    else if (frame_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_link.sv
// Directed bench for spi_slave_link: a table of whole frames plus hand sequences for
// reset mid-frame, zero-bit frames and error-counter saturation.
module tb_spi_slave_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, spi_mosi, spi_cs;
  logic        spi_miso;
  logic        rx_valid;
  logic [3:0]  rx_index;
  logic [27:0] rx_data;
  logic        tx_valid;
  logic [3:0]  tx_index;
  logic [27:0] tx_data;
  logic        tx_ready;
  logic [27:0] status;
  logic        frame_err;
  logic [7:0]  err_count;

  spi_slave_link #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs),
    .rx_valid(rx_valid), .rx_index(rx_index), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_index(tx_index), .tx_data(tx_data), .tx_ready(tx_ready),
    .status(status), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_rxv = 0, n_err = 0, n_txr = 0;
  always @(posedge clk) begin
    if (rx_valid)  n_rxv++;
    if (frame_err) n_err++;
    if (tx_ready)  n_txr++;
  end

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] exp_ec(input int n);
`ifdef SPI_SLAVE_ERRCNT_EN
    return (n > 255) ? 32'd255 : n;
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic sck_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (5) @(negedge clk);
    spi_clk = 1'b1;
    m = spi_miso;
    repeat (5) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w, input int nb, output logic [31:0] mr);
    logic m;
    mr = '0;
    @(negedge clk) spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      sck_bit(w[31 - (i % 32)], m);
      if (i < 32) mr = {mr[30:0], m};
    end
    repeat (6) @(negedge clk);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] mosi;
    int          nbits;
    logic        txv;
    logic [3:0]  txi;
    logic [27:0] txd;
    logic [27:0] st;
    int          e_rxv, e_err, e_txr;
    logic        chk_miso;
    logic [31:0] e_miso;
    logic [3:0]  e_idx;
    logic [27:0] e_dat;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] mr;
    logic        m;
    int r0, e0, t0, errs;

    vt[0] = '{32'h3ABCDEF1, 32, 1'b0, 4'h0, 28'h0,       28'h0001234, 1, 0, 0, 1'b1, 32'h00001234, 4'h3, 28'hABCDEF1};
    vt[1] = '{32'h12345678, 32, 1'b1, 4'h5, 28'h7654321, 28'h0000000, 1, 0, 1, 1'b1, 32'h57654321, 4'h1, 28'h2345678};
    vt[2] = '{32'hFFFFFFFF, 20, 1'b0, 4'h0, 28'h0,       28'h0000000, 0, 1, 0, 1'b0, 32'h0,        4'h1, 28'h2345678};
    vt[3] = '{32'h0F0F0F0F, 33, 1'b0, 4'h0, 28'h0,       28'h0000000, 0, 1, 0, 1'b0, 32'h0,        4'h1, 28'h2345678};
    vt[4] = '{32'h00000000, 0,  1'b1, 4'h9, 28'h1111111, 28'h0000000, 0, 1, 1, 1'b0, 32'h0,        4'h1, 28'h2345678};
    vt[5] = '{32'hA5A5A5A5, 32, 1'b1, 4'hF, 28'h0000001, 28'h0000000, 1, 0, 1, 1'b1, 32'hF0000001, 4'hA, 28'h5A5A5A5};
    vt[6] = '{32'hC0000000, 32, 1'b0, 4'h0, 28'h0,       28'hFFFFFFF, 1, 0, 0, 1'b1, 32'h0FFFFFFF, 4'hC, 28'h0000000};

    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1;
    tx_valid = 1'b0; tx_index = '0; tx_data = '0; status = '0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset_outputs", {rx_valid, frame_err, tx_ready, spi_miso}, 32'h0);
    chk("reset_rx", {rx_index, rx_data}, 32'h0);
    chk("reset_err_count", {24'h0, err_count}, 32'h0);

    errs = 0;
    for (int k = 0; k < 7; k++) begin
      tx_valid = vt[k].txv; tx_index = vt[k].txi; tx_data = vt[k].txd; status = vt[k].st;
      r0 = n_rxv; e0 = n_err; t0 = n_txr;
      run_frame(vt[k].mosi, vt[k].nbits, mr);
      tx_valid = 1'b0;
      errs += vt[k].e_err;
      chk($sformatf("v%0d_rx_valid_pulses", k), n_rxv - r0, vt[k].e_rxv);
      chk($sformatf("v%0d_frame_err_pulses", k), n_err - e0, vt[k].e_err);
      chk($sformatf("v%0d_tx_ready_pulses", k), n_txr - t0, vt[k].e_txr);
      if (vt[k].chk_miso) chk($sformatf("v%0d_miso_word", k), mr, vt[k].e_miso);
      chk($sformatf("v%0d_rx_index", k), {28'h0, rx_index}, {28'h0, vt[k].e_idx});
      chk($sformatf("v%0d_rx_data", k), {4'h0, rx_data}, {4'h0, vt[k].e_dat});
      chk($sformatf("v%0d_err_count", k), {24'h0, err_count}, exp_ec(errs));
    end

    // Reset at bit 10 with CS held low; the rest of that frame must be ignored.
    r0 = n_rxv; e0 = n_err;
    @(negedge clk) spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) sck_bit(1'b1, m);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) sck_bit(1'b0, m);
    repeat (6) @(negedge clk);
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    errs = 0;
    chk("rst_mid_no_rx_valid", n_rxv - r0, 0);
    chk("rst_mid_no_frame_err", n_err - e0, 0);
    chk("rst_mid_rx_cleared", {rx_index, rx_data}, 32'h0);
    chk("rst_mid_err_count", {24'h0, err_count}, 32'h0);

    status = 28'h0000ABC;
    r0 = n_rxv;
    run_frame(32'hF0000001, 32, mr);
    chk("post_rst_rx_valid", n_rxv - r0, 1);
    chk("post_rst_rx_index", {28'h0, rx_index}, 32'hF);
    chk("post_rst_rx_data", {4'h0, rx_data}, 32'h1);
    chk("post_rst_miso", mr, 32'h00000ABC);

    // CS low for a single clock: cs_fall and cs_rise on consecutive cycles.
    tx_valid = 1'b1; tx_index = 4'h7; tx_data = 28'h00000AA;
    r0 = n_rxv; e0 = n_err; t0 = n_txr;
    @(negedge clk) spi_cs = 1'b0;
    @(negedge clk) spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    tx_valid = 1'b0;
    errs++;
    chk("zero_bit_frame_err", n_err - e0, 1);
    chk("zero_bit_tx_ready", n_txr - t0, 1);
    chk("zero_bit_no_rx_valid", n_rxv - r0, 0);
    chk("zero_bit_err_count", {24'h0, err_count}, exp_ec(errs));

    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) spi_cs = 1'b0;
      @(negedge clk) spi_cs = 1'b1;
      repeat (7) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    errs += 300;
    chk("sat_frame_err_pulses", n_err - e0, 300);
    chk("sat_err_count", {24'h0, err_count}, exp_ec(errs));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
